ffd_pipe: RTL and testbench
===========================

Name: ffd_pipe

Overview:
Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline with per-stage valid tracking, global advance enable, synchronous flush and a programmable reset value. Used wherever the design needs aligned multi-cycle delays of data buses, such as display and keypad paths, with stall and flush control. It also reports pipeline occupancy.

Parameters:
WIDTH, 8, data bus width in bits (>=1)
DEPTH, 4, number of register stages, i.e. latency in enabled cycles (>=1)
RESET_VALUE, 0, WIDTH-bit value loaded into every data stage on reset or flush

Ports:
clock  input  1  rising-edge clock, sole clock domain
reset_n  input  1  reset, synchronous and active-low; sampled on rising edge of clock
enable  input  1  advance pipeline by one stage this cycle
flush  input  1  synchronous clear of all stages; active-high
data_in  input  WIDTH  data presented to stage 0
valid_in  input  1  qualifies data_in
data_out  output  WIDTH  contents of last stage (DEPTH-1)
valid_out  output  1  valid bit of last stage
fill_count  output  clog2(DEPTH+1)  number of stages currently holding valid data
full  output  1  high when fill_count == DEPTH
empty  output  1  high when fill_count == 0

Behaviour:
- Storage: DEPTH data registers stage[0..DEPTH-1] (WIDTH bits each) and DEPTH valid bits vld[0..DEPTH-1]. All outputs come straight from registers; there is no combinational path from inputs to outputs.
- Priority at each rising edge, highest first: reset_n==0, then flush==1, then enable==1, then hold.
- Reset (reset_n low at edge): every stage <= RESET_VALUE, every vld <= 0, fill_count <= 0. After the edge: data_out=RESET_VALUE, valid_out=0, full=0, empty=1. Asynchronous assertion has no effect until the next edge.
- Flush (reset_n high, flush high): same effect as reset. The data_in/valid_in presented on that cycle are discarded, even when enable is high.
- Advance (enable high, no reset/flush):
  - stage[0] <= data_in, vld[0] <= valid_in.
  - stage[k] <= stage[k-1] and vld[k] <= vld[k-1] for k = 1..DEPTH-1.
  - Contents of stage[DEPTH-1] are dropped.
- Hold (enable low): all registers keep their values. valid_in is ignored.
- Latency: a word accepted on an enabled edge appears on data_out after exactly DEPTH enabled edges. Disabled cycles stretch the wall-clock latency but never reorder or drop data.
- Invalid words (valid_in=0) occupy a slot and propagate like valid ones. Their data field still shifts and is not forced to RESET_VALUE.
- fill_count: registered and updated on the same edge as the valid bits. On advance: next = current + valid_in - vld[DEPTH-1]. Otherwise it holds, or goes to 0 on reset/flush. It never exceeds DEPTH and never underflows, and it must always equal popcount(vld).
- full/empty: registered or decoded from registered fill_count; no input-to-output path.
- DEPTH==1 degenerates to a single enabled flip-flop with a valid bit. It must synthesise with no zero-width or negative-index constructs.
- Reset or flush in the middle of a stream: all in-flight words are lost. The next accepted word has full DEPTH latency.

Test Plan:
- Reset: WIDTH=8, DEPTH=4, RESET_VALUE=8'hA5; hold reset_n=0 for 2 edges -> data_out=8'hA5, valid_out=0, fill_count=0, empty=1, full=0.
- Streaming: enable=1, valid_in=1, data_in=8'h01,02,03,04,05 on successive edges -> data_out=8'h01 after the 4th edge, then 02, 03…; valid_out=1 from that edge on; full=1 after the 4th edge.
- Stall: load 8'h11,22 with enable, then hold enable=0 for 3 cycles with data_in=8'hFF -> all registers unchanged, fill_count stays 2. Re-enable with valid_in=0 -> 8'h11 reaches data_out 4 enabled edges after its entry.
- Bubble accounting: alternate valid_in 1,0,1,0 with enable=1 -> fill_count sequence 1,1,2,2. Steady state stays at 2; valid_out toggles once the pipe is filled.
- Flush priority: pipeline full, assert flush=1 with enable=1, valid_in=1, data_in=8'h77 -> next edge: fill_count=0, valid_out=0, data_out=8'hA5; 8'h77 is never output.
- Reset beats flush/enable, plus DEPTH=1 build: reset_n=0 with flush=0, enable=1 -> reset values. With DEPTH=1, data_in=8'h3C enabled -> data_out=8'h3C and valid_out=1 after 1 edge.

Source files
------------

// File: rtl/ffd_pipe_if.sv
// ffd_pipe_if: control, data and status bundle for the ffd_pipe delay line.
// The master drives the stream and control signals. The slave (the pipe) reports its contents and occupancy.
interface ffd_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);
    logic             enable;
    logic             flush;
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic [CW-1:0]    fill_count;
    logic             full;
    logic             empty;
    modport master (
        output enable, flush, data_in, valid_in,
        input  data_out, valid_out, fill_count, full, empty
    );
    modport slave (
        input  enable, flush, data_in, valid_in,
        output data_out, valid_out, fill_count, full, empty
    );
endinterface

// File: rtl/ffd_pipe.sv
// ffd_pipe: WIDTH x DEPTH register delay line with per-stage valid bits, stall, flush and occupancy.
// Every output is taken from a register or decoded from one, so no path runs from the inputs to the outputs.
module ffd_pipe #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic        i_clock,
    input logic        i_reset_n,
    ffd_pipe_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [CW-1:0]    r_fill;
    logic             w_clear;
    logic [DEPTH-1:0] w_vld_next;
    logic [CW-1:0]    w_fill_next;
    assign w_clear     = !i_reset_n || bus.flush;
    // The shift-and-or form keeps DEPTH==1 free of negative part-selects.
    assign w_vld_next  = (r_vld << 1) | DEPTH'(bus.valid_in);
    assign w_fill_next = r_fill + CW'(bus.valid_in) - CW'(r_vld[DEPTH-1]);
    always_ff @(posedge i_clock) begin
        if (w_clear) begin
            for (int k = 0; k < DEPTH; k++) r_stage[k] <= RESET_VALUE;
            r_vld  <= '0;
            r_fill <= '0;
        end else if (bus.enable) begin
            r_stage[0] <= bus.data_in;
            for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
            r_vld  <= w_vld_next;
            r_fill <= w_fill_next;
        end
    end
    assign bus.data_out   = r_stage[DEPTH-1];
    assign bus.valid_out  = r_vld[DEPTH-1];
    assign bus.fill_count = r_fill;
    assign bus.full       = r_fill == CW'(DEPTH);
    assign bus.empty      = r_fill == '0;
endmodule

// File: tb/tb_ffd_pipe.sv
// tb_ffd_pipe: directed vector table plus randomized run against a queue model, for DEPTH=4 and DEPTH=1 builds.
module tb_ffd_pipe;
    localparam logic [7:0] RV4 = 8'hA5;
    localparam logic [7:0] RV1 = 8'h5A;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    ffd_pipe_if #(.WIDTH(8), .DEPTH(4)) b4();
    ffd_pipe_if #(.WIDTH(8), .DEPTH(1)) b1();
    ffd_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(RV4)) dut4 (.i_clock(clk), .i_reset_n(rst_n), .bus(b4));
    ffd_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VALUE(RV1)) dut1 (.i_clock(clk), .i_reset_n(rst_n), .bus(b1));

    typedef struct {
        logic       r, f, e, v;
        logic [7:0] d;
        logic [7:0] dout;
        logic       vout;
        int         fill;
    } vec_t;
    vec_t tbl[$];
    logic [8:0] m4[$];
    logic [8:0] m1[$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void add(logic r, f, e, v, logic [7:0] d, logic [7:0] dout, logic vout, int fill);
        vec_t t;
        t.r = r; t.f = f; t.e = e; t.v = v; t.d = d; t.dout = dout; t.vout = vout; t.fill = fill;
        tbl.push_back(t);
    endfunction

    // Each word is {valid, data}; the queue holds the words still inside the pipe, newest at the front.
    function automatic void model_edge(logic r, f, e, v, logic [7:0] d);
        if (!r || f) begin
            m4.delete();
            m1.delete();
            for (int i = 0; i < 4; i++) m4.push_back({1'b0, RV4});
            m1.push_back({1'b0, RV1});
        end else if (e) begin
            m4.push_front({v, d});
            void'(m4.pop_back());
            m1.push_front({v, d});
            void'(m1.pop_back());
        end
    endfunction

    function automatic int m4_fill();
        int n = 0;
        foreach (m4[i]) n += int'(m4[i][8]);
        return n;
    endfunction

    function automatic void chk4(string tag, logic [7:0] dout, logic vout, int fill);
        chk({tag, "_dout"},  32'(b4.data_out),   32'(dout));
        chk({tag, "_vout"},  32'(b4.valid_out),  32'(vout));
        chk({tag, "_fill"},  32'(b4.fill_count), 32'(fill));
        chk({tag, "_full"},  32'(b4.full),       32'(fill == 4));
        chk({tag, "_empty"}, 32'(b4.empty),      32'(fill == 0));
    endfunction

    function automatic void chk1(string tag);
        int fill = int'(m1[0][8]);
        chk({tag, "_d1_dout"},  32'(b1.data_out),   32'(m1[0][7:0]));
        chk({tag, "_d1_vout"},  32'(b1.valid_out),  32'(m1[0][8]));
        chk({tag, "_d1_fill"},  32'(b1.fill_count), 32'(fill));
        chk({tag, "_d1_full"},  32'(b1.full),       32'(fill == 1));
        chk({tag, "_d1_empty"}, 32'(b1.empty),      32'(fill == 0));
    endfunction

    task automatic step(logic r, f, e, v, logic [7:0] d);
        rst_n = r;
        b4.flush = f; b4.enable = e; b4.valid_in = v; b4.data_in = d;
        b1.flush = f; b1.enable = e; b1.valid_in = v; b1.data_in = d;
        @(posedge clk);
        model_edge(r, f, e, v, d);
        #1;
    endtask

    initial begin
        // reset held for two edges
        add(0, 0, 0, 0, 8'h00, RV4, 0, 0);
        add(0, 0, 0, 0, 8'h00, RV4, 0, 0);
        // streaming 01..05
        add(1, 0, 1, 1, 8'h01, RV4, 0, 1);
        add(1, 0, 1, 1, 8'h02, RV4, 0, 2);
        add(1, 0, 1, 1, 8'h03, RV4, 0, 3);
        add(1, 0, 1, 1, 8'h04, 8'h01, 1, 4);
        add(1, 0, 1, 1, 8'h05, 8'h02, 1, 4);
        // flush beats enable while full; 77 is discarded
        add(1, 1, 1, 1, 8'h77, RV4, 0, 0);
        // stall
        add(1, 0, 1, 1, 8'h11, RV4, 0, 1);
        add(1, 0, 1, 1, 8'h22, RV4, 0, 2);
        add(1, 0, 0, 1, 8'hFF, RV4, 0, 2);
        add(1, 0, 0, 1, 8'hFF, RV4, 0, 2);
        add(1, 0, 0, 1, 8'hFF, RV4, 0, 2);
        add(1, 0, 1, 0, 8'h00, RV4, 0, 2);
        add(1, 0, 1, 0, 8'h00, 8'h11, 1, 2);
        add(1, 0, 1, 0, 8'h00, 8'h22, 1, 1);
        add(1, 0, 1, 0, 8'h00, 8'h00, 0, 0);
        // bubbles
        add(1, 0, 1, 1, 8'h31, 8'h00, 0, 1);
        add(1, 0, 1, 0, 8'h32, 8'h00, 0, 1);
        add(1, 0, 1, 1, 8'h33, 8'h00, 0, 2);
        add(1, 0, 1, 0, 8'h34, 8'h31, 1, 2);
        add(1, 0, 1, 1, 8'h35, 8'h32, 0, 2);
        add(1, 0, 1, 0, 8'h36, 8'h33, 1, 2);
        // reset beats flush and enable
        add(0, 0, 1, 1, 8'h99, RV4, 0, 0);
        add(1, 0, 1, 1, 8'h41, RV4, 0, 1);
        add(0, 1, 1, 1, 8'h42, RV4, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].f, tbl[i].e, tbl[i].v, tbl[i].d);
            chk4($sformatf("vec%0d", i), tbl[i].dout, tbl[i].vout, tbl[i].fill);
            chk1($sformatf("vec%0d", i));
        end

        // DEPTH=1 single-edge latency
        step(1, 0, 1, 1, 8'h3C);
        chk("d1_3c_dout", 32'(b1.data_out), 32'h3C);
        chk("d1_3c_vout", 32'(b1.valid_out), 32'h1);
        chk("d1_3c_full", 32'(b1.full), 32'h1);

        for (int n = 0; n < 400; n++) begin
            logic r, f, e, v;
            logic [7:0] d;
            r = $urandom_range(0, 49) != 0;
            f = $urandom_range(0, 29) == 0;
            e = $urandom_range(0, 3) != 0;
            v = 1'($urandom);
            d = 8'($urandom);
            step(r, f, e, v, d);
            chk4($sformatf("rnd%0d", n), m4[3][7:0], m4[3][8], m4_fill());
            chk1($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
